// File: rtl/spawn_controller_pkg.sv
// Shared game-core types: the tetromino control word, spawn FSM states and
// default spawn coordinates.
package spawn_controller_pkg;

  localparam int DEF_SPAWN_X = 3;
  localparam int DEF_SPAWN_Y = 0;

  typedef struct packed {
    logic [3:0] x;
    logic [4:0] y;
  } coord_t;

  typedef struct packed {
    logic [2:0] idx;
    logic [1:0] rotation;
    coord_t     coordinate;
  } tetromino_ctrl;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    GEN_WAIT,
    CHECK,
    ACTIVE,
    GAME_OVER
  } spawn_state_t;

  // Keeps the piece shape, resets orientation and places it at the spawn point.
  function automatic tetromino_ctrl at_spawn(tetromino_ctrl p, logic [3:0] x, logic [4:0] y);
    tetromino_ctrl r;
    r              = p;
    r.rotation     = '0;
    r.coordinate.x = x;
    r.coordinate.y = y;
    return r;
  endfunction

endpackage

// File: rtl/spawn_check_timer.sv
// Cycle counter for bounded handshakes: counts while enabled, flags the cycle
// on which the MAX-th enabled cycle is reached.
module spawn_check_timer #(
  parameter int MAX = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/spawn_controller.sv
// Spawn sequencer: pulses the generator, checks each new piece against the
// board, tracks the active piece and the hold slot, and detects game over.
module spawn_controller
  import spawn_controller_pkg::*;
#(
  parameter int SPAWN_X       = DEF_SPAWN_X,
  parameter int SPAWN_Y       = DEF_SPAWN_Y,
  parameter int CHECK_TIMEOUT = 255,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             restart,
  input  logic             lock_pulse,
  input  logic             hold_req,
  input  tetromino_ctrl    gen_piece,
  output logic             gen_enable,
  output logic             chk_req,
  output tetromino_ctrl    chk_piece,
  input  logic             chk_ack,
  input  logic             chk_collide,
  output tetromino_ctrl    active_piece,
  output logic             active_valid,
  output tetromino_ctrl    hold_piece,
  output logic             hold_valid,
  output logic             hold_allowed,
  output logic             game_over,
  output logic             timeout_err,
  output logic [CNT_W-1:0] piece_count,
  output spawn_state_t     dbg_state
);

  localparam logic [3:0] SX = 4'(SPAWN_X);
  localparam logic [4:0] SY = 5'(SPAWN_Y);

  spawn_state_t     r_state, w_next;
  tetromino_ctrl    r_candidate, r_active, r_hold;
  logic             r_hold_valid, r_hold_allowed, r_timeout_err;
  logic [CNT_W-1:0] r_count;
  logic             w_lock, w_hold, w_expired;

  // Lock has priority over hold; a hold is only honoured once per locked piece.
  assign w_lock = (r_state == ACTIVE) && lock_pulse;
  assign w_hold = (r_state == ACTIVE) && !lock_pulse && hold_req && r_hold_allowed;

  spawn_check_timer #(.MAX(CHECK_TIMEOUT)) u_timer (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clear   (w_next != CHECK),
    .i_enable  (r_state == CHECK),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Check handshake: chk_req and chk_piece hold steady from entry into CHECK
  // until the cycle chk_ack is seen; chk_collide is only meaningful with chk_ack.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (start) w_next = GEN;
      GEN:       w_next = GEN_WAIT;
      GEN_WAIT:  w_next = CHECK;
      CHECK: begin
        if (chk_ack)        w_next = chk_collide ? GAME_OVER : ACTIVE;
        else if (w_expired) w_next = GAME_OVER;
      end
      ACTIVE: begin
        if (w_lock)      w_next = GEN;
        else if (w_hold) w_next = r_hold_valid ? CHECK : GEN;
      end
      GAME_OVER: if (restart) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_candidate    <= '0;
      r_active       <= '0;
      r_hold         <= '0;
      r_hold_valid   <= 1'b0;
      r_hold_allowed <= 1'b1;
      r_timeout_err  <= 1'b0;
      r_count        <= '0;
    end else begin
      case (r_state)
        GEN: if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
        GEN_WAIT: r_candidate <= at_spawn(gen_piece, SX, SY);
        CHECK: begin
          if (chk_ack && !chk_collide)  r_active      <= r_candidate;
          else if (!chk_ack && w_expired) r_timeout_err <= 1'b1;
        end
        ACTIVE: begin
          if (w_lock) begin
            r_hold_allowed <= 1'b1;
          end else if (w_hold) begin
            r_hold_allowed <= 1'b0;
            r_hold         <= at_spawn(r_active, SX, SY);
            r_hold_valid   <= 1'b1;
            if (r_hold_valid) r_candidate <= at_spawn(r_hold, SX, SY);
          end
        end
        GAME_OVER: begin
          if (restart) begin
            r_hold_valid   <= 1'b0;
            r_hold         <= '0;
            r_count        <= '0;
            r_timeout_err  <= 1'b0;
            r_active       <= '0;
            r_hold_allowed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gen_enable   = (r_state == GEN);
  assign chk_req      = (r_state == CHECK);
  assign chk_piece    = chk_req ? r_candidate : '0;
  assign active_piece = r_active;
  assign active_valid = (r_state == ACTIVE);
  assign hold_piece   = r_hold;
  assign hold_valid   = r_hold_valid;
  assign hold_allowed = r_hold_allowed;
  assign game_over    = (r_state == GAME_OVER);
  assign timeout_err  = r_timeout_err;
  assign piece_count  = r_count;
  assign dbg_state    = r_state;

endmodule

// File: doc/spawn_controller.md
Name: spawn_controller

Overview:
Sequences the tetromino generator for the game core.
- Issues generator enable pulses at game start and after every lock.
- Latches the spawned piece as the active piece.
- Runs a spawn-collision check against the board through a req/ack handshake, and declares game over on a blocked spawn.
- Owns the hold slot: one hold/swap per locked piece.
- Sits between generate_tetromino and the board/game FSM.

Parameters:
SPAWN_X, 3, x coordinate forced onto every spawned or swapped-in piece
SPAWN_Y, 0, y coordinate forced onto every spawned or swapped-in piece
CHECK_TIMEOUT, 255, max cycles to wait for chk_ack before flagging an error (must be ≥1)
CNT_W, 16, width of piece_count

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse: begin game from IDLE
restart  in  1  pulse: leave GAME_OVER, return to IDLE
lock_pulse  in  1  active piece has locked into the board
hold_req  in  1  player hold request (single-cycle pulse)
gen_piece  in  tetromino_ctrl  generator current-piece output (t_out)
gen_enable  out  1  one-cycle enable to generator
chk_req  out  1  collision check request, level, held until chk_ack
chk_piece  out  tetromino_ctrl  candidate piece under check
chk_ack  in  1  check result valid (one cycle)
chk_collide  in  1  candidate overlaps board; sampled with chk_ack
active_piece  out  tetromino_ctrl  current falling piece
active_valid  out  1  active_piece is live (state ACTIVE)
hold_piece  out  tetromino_ctrl  held piece
hold_valid  out  1  hold slot occupied
hold_allowed  out  1  hold permitted for current piece
game_over  out  1  level, high in GAME_OVER
timeout_err  out  1  sticky; set when a check timed out
piece_count  out  CNT_W  pieces spawned from generator, saturating

Behaviour:
- Reset values (async on rst_n low):
  - State IDLE.
  - All 1-bit outputs 0, except hold_allowed = 1.
  - active_piece, hold_piece, chk_piece = '0.
  - piece_count = 0. Timeout counter = 0.
- States: IDLE, GEN, GEN_WAIT, CHECK, ACTIVE, GAME_OVER.
- IDLE:
  - start → GEN.
  - All other inputs ignored.
- GEN:
  - gen_enable = 1 for exactly this cycle.
  - piece_count += 1, saturating at all-ones.
  - Next state GEN_WAIT. The generator output is registered, so new gen_piece is valid one cycle later.
- GEN_WAIT:
  - candidate ← gen_piece with rotation = 0, x = SPAWN_X, y = SPAWN_Y.
  - Next state CHECK.
- CHECK:
  - chk_req = 1 and chk_piece = candidate; both stable until ack.
  - Timeout counter increments each cycle.
  - chk_ack with chk_collide = 0 → ACTIVE; active_piece ← candidate.
  - chk_ack with chk_collide = 1 → GAME_OVER.
  - Counter reaches CHECK_TIMEOUT with no ack → GAME_OVER and timeout_err ← 1.
  - Ack arriving in the same cycle as the timeout: the ack wins.
  - Counter clears on leaving CHECK.
- ACTIVE:
  - active_valid = 1.
  - lock_pulse → hold_allowed ← 1, then → GEN.
  - hold_req with hold_allowed = 1:
    - hold_allowed ← 0.
    - hold_piece ← active_piece with rotation 0 and spawn coordinates.
    - hold_valid ← 1.
    - If hold was empty → GEN.
    - If hold was occupied → candidate ← old hold_piece (spawn coordinates, rotation 0), then → CHECK. piece_count is unchanged.
  - hold_req with hold_allowed = 0 is ignored.
  - lock_pulse and hold_req in the same cycle: lock wins, hold ignored.
- GAME_OVER:
  - game_over = 1. All inputs ignored except restart.
  - restart → IDLE; clears hold_valid, hold_piece, piece_count, timeout_err, active_piece; sets hold_allowed ← 1.
- start outside IDLE and restart outside GAME_OVER are ignored.
- gen_enable is asserted only in GEN. It must never be high on two consecutive cycles.
- Reset mid-operation (including mid-CHECK): immediate return to reset values. chk_req drops asynchronously.

Decomposition:
- Shared package/GLOBAL.sv: existing tetromino_ctrl type; new spawn_state_t enum; SPAWN_X and SPAWN_Y defaults as global constants.
- Sub-module spawn_check_timer: timeout counter with clear/enable/expired. Small but reused by other handshakes.
- Everything else is a single FSM plus datapath registers in one module.

Test Plan:
- Reset, start, bench acks with collide = 0 after 2 cycles → gen_enable high exactly 1 cycle; chk_req high 3 cycles; active_valid rises; active_piece.coordinate = (3,0), rotation 0; piece_count = 1.
- ACTIVE, lock_pulse → gen_enable pulse; next check passes; piece_count = 2; hold_allowed = 1.
- Hold sequence with collide = 0 on every check:
  - hold_req with hold empty → hold_valid = 1; hold_piece.idx = prior active idx; new piece spawned; piece_count +1.
  - Second hold_req before lock → ignored.
  - After lock, hold_req → swap; CHECK entered with no gen_enable; piece_count unchanged.
- Check answered with chk_collide = 1 → game_over = 1, active_valid = 0. restart → IDLE with hold_valid = 0, piece_count = 0.
- CHECK_TIMEOUT = 4, no ack → game_over and timeout_err set 4 cycles after chk_req rose. Repeat with the ack arriving on cycle 4 → ACTIVE, no error.
- Simultaneous lock_pulse + hold_req → GEN taken, hold_piece unchanged. rst_n pulsed low mid-CHECK → chk_req = 0 immediately; state IDLE.
